spi_shift_engine: RTL and testbench
===================================

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 Parameter: DATA_W, default 8, shift register width in bits (legal range 2..32).
REQ-002 Derived constant: CNT_W = clog2(DATA_W+1), the width of the length field and bit counter.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tx_valid  input  1  transfer request.
REQ-006 tx_ready  output  1  engine accepts a request; high iff state IDLE.
REQ-007 tx_data  input  DATA_W  transmit word; bits [L-1:0] are sent.
REQ-008 len  input  CNT_W  transfer length L in bits; 0 or >DATA_W SHALL mean DATA_W.
REQ-009 lsb_first  input  1  1 = LSB-first, 0 = MSB-first.
REQ-010 shift_en  input  1  one-cycle bit strobe from the SPI clock generator.
REQ-011 abort  input  1  cancel the transfer in progress.
REQ-012 sdi  input  1  serial data in, sampled on a shift_en cycle.
REQ-013 sdo  output  1  serial data out.
REQ-014 rx_data  output  DATA_W  received word, right-aligned, upper bits zero.
REQ-015 rx_valid  output  1  one-cycle pulse; rx_data is valid.
REQ-016 busy  output  1  high when state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-018 IDLE->SHIFT on tx_valid&&tx_ready: latch tx_data, the normalised L and lsb_first; clear the bit counter.
REQ-019 MSB-first load SHALL align tx_data[L-1] to the outgoing bit position; LSB-first load SHALL place tx_data[0] at the outgoing bit position.
REQ-020 In SHIFT, sdo SHALL present the current outgoing bit combinationally from the register; in IDLE and DONE, sdo SHALL be 0.
REQ-021 On each shift_en cycle in SHIFT, the engine SHALL capture sdi into the vacated end, advance the register by one bit and increment the counter.
REQ-022 On the shift_en cycle with counter = L-1, the next state SHALL be DONE.
REQ-023 In DONE, rx_data SHALL be updated with the received L bits, right-aligned, first-received bit at position L-1 for MSB-first, and the first-received bit at position 0 for LSB-first.
REQ-024 rx_valid SHALL be high for exactly the cycle after the final shift_en, then DONE->IDLE.
REQ-025 rx_data SHALL hold its value until the next DONE.
REQ-026 abort in SHIFT SHALL force IDLE on the next edge with no rx_valid, and abort SHALL take priority over a same-cycle shift_en.
REQ-027 abort in IDLE or DONE SHALL be ignored, and DONE SHALL still produce rx_valid.
REQ-028 shift_en in IDLE or DONE SHALL be ignored.
REQ-029 tx_valid while tx_ready=0 SHALL be ignored and not queued.
REQ-030 The register, counter and latched config SHALL not change in SHIFT without shift_en.
REQ-031 Back-to-back operation: a request SHALL be accepted in the IDLE cycle immediately following DONE.

Reset
REQ-032 While rst is high: state IDLE, register 0, counter 0, latched config 0, rx_data 0, rx_valid 0, sdo 0, busy 0.
REQ-033 tx_ready SHALL read 1 after the first reset edge.
REQ-034 rst SHALL override tx_valid, shift_en and abort in the same cycle.
REQ-035 Reset mid-transfer SHALL discard the transfer with no rx_valid.

Structure
REQ-036 Shared package spi_pkg SHALL hold the state typedef (IDLE/SHIFT/DONE) and a length-normalisation function (0 or >DATA_W -> DATA_W).
REQ-037 One sub-module is natural: spi_bit_cnt, a CNT_W counter with clear, enable and terminal flag (count = L-1).
REQ-038 All other logic SHALL be inline in spi_shift_engine.

Verification (DATA_W=8)
REQ-039 MSB-first, L=8, tx 0xA5, sdi bits 0,0,1,1,1,1,0,0 -> sdo 1,0,1,0,0,1,0,1; rx_data 0x3C; rx_valid one cycle after the 8th strobe.
REQ-040 LSB-first, L=8, tx 0x0F, sdi bits 1,0,0,0,0,0,0,0 -> sdo 1,1,1,1,0,0,0,0; rx_data 0x01.
REQ-041 MSB-first, L=4, tx 0xFB, sdi 1,1,0,0 -> sdo 1,0,1,1; rx_data 0x0C; len=0 run transfers 8 bits.
REQ-042 Abort after 3 strobes, with shift_en high in the same cycle -> no rx_valid, tx_ready=1 next cycle; the next transfer tx 0x55 is sent correctly.
REQ-043 tx_valid with tx 0xFF during SHIFT and shift_en in IDLE -> no effect on the active transfer or the register; sdo 0 in IDLE.
REQ-044 rst asserted after 5 strobes -> next cycle all outputs at reset values, no rx_valid; a new transfer is then accepted.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and helpers for the SPI shift engine.
//               - state_e  : engine FSM states (IDLE/SHIFT/DONE)
//               - norm_len : maps a requested length of 0 or more than the
//                            register width onto the full register width
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Wide enough for a length field of a 32-bit register (clog2(33) = 6).
  localparam int MAX_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [MAX_CNT_W-1:0] norm_len(
    input logic [MAX_CNT_W-1:0] len,
    input int unsigned          data_w
  );
    logic [MAX_CNT_W-1:0] full;
    full = MAX_CNT_W'(data_w);
    if ((len == '0) || (len > full)) begin
      return full;
    end
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bit_cnt.sv
`default_nettype none
// ============================================================================
// Module      : spi_bit_cnt
// Description : Bit counter for the SPI shift engine.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count one bit
//   len      : transfer length L (already normalised, >= 1)
//   term     : high while the count equals L-1 (last bit of the transfer)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bit_cnt
  import spi_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] len,
  output logic             term
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == (len - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine
// Description : Full-duplex SPI shift register with programmable length and
//               bit order. One bit is exchanged per shift_en strobe.
//   clk, rst             : clock, synchronous active-high reset
//   tx_valid / tx_ready  : request handshake (ready only in IDLE)
//   tx_data, len         : transmit word and length L (0 or >DATA_W = DATA_W)
//   lsb_first            : 1 = LSB-first, 0 = MSB-first
//   shift_en, sdi, sdo   : bit strobe, serial in, serial out
//   abort                : cancels an active transfer
//   rx_data, rx_valid    : received word (right-aligned) and its 1-cycle pulse
//   busy                 : engine not idle
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CNT_W-1:0]  len,
  input  logic              lsb_first,
  input  logic              shift_en,
  input  logic              abort,
  input  logic              sdi,
  output logic              sdo,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic              lsb_q, lsb_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;

  logic [CNT_W-1:0]  len_norm;
  logic [CNT_W-1:0]  pad_in;
  logic [CNT_W-1:0]  pad_q;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_term;

  assign len_norm = CNT_W'(norm_len(MAX_CNT_W'(len), DATA_W));
  // Number of unused register bits for the requested / latched length.
  assign pad_in   = CNT_W'(DATA_W) - len_norm;
  assign pad_q    = CNT_W'(DATA_W) - len_q;

  assign cnt_en   = (state_q == SHIFT) && shift_en && !abort;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    len_d     = len_q;
    lsb_d     = lsb_q;
    rx_data_d = rx_data_q;
    cnt_clr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = SHIFT;
          // MSB-first shifts out of the top, so tx_data[L-1] is moved up to
          // bit DATA_W-1; LSB-first shifts out of bit 0 and loads unchanged.
          sr_d    = lsb_first ? tx_data : (tx_data << pad_in);
          len_d   = len_norm;
          lsb_d   = lsb_first;
          cnt_clr = 1'b1;
        end
      end

      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (shift_en) begin
          sr_d = lsb_q ? {sdi, sr_q[DATA_W-1:1]} : {sr_q[DATA_W-2:0], sdi};
          if (cnt_term) begin
            state_d = DONE;
            // MSB-first: received bits sit in [L-1:0], tx leftovers above.
            // LSB-first: received bits sit in the top L bits, so right-align.
            rx_data_d = lsb_q ? (sr_d >> pad_q)
                              : (sr_d & ({DATA_W{1'b1}} >> pad_q));
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      len_q     <= '0;
      lsb_q     <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      len_q     <= len_d;
      lsb_q     <= lsb_d;
      rx_data_q <= rx_data_d;
    end
  end

  spi_bit_cnt #(
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .len  (len_q),
    .term (cnt_term)
  );

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign rx_valid = (state_q == DONE);
  assign rx_data  = rx_data_q;
  assign sdo      = (state_q == SHIFT) ? (lsb_q ? sr_q[0] : sr_q[DATA_W-1]) : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_shift_engine
// Description : Self-checking bench for spi_shift_engine (DATA_W = 8).
//               Directed vectors plus randomized transfers compared against
//               a bit-list reference model of the transfer rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_shift_engine;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [CNT_W-1:0]  len;
  logic              lsb_first;
  logic              shift_en;
  logic              abort;
  logic              sdi;
  logic              sdo;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] prev_rx = '0;

  spi_shift_engine #(
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .len       (len),
    .lsb_first (lsb_first),
    .shift_en  (shift_en),
    .abort     (abort),
    .sdi       (sdi),
    .sdo       (sdo),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag, input logic [DATA_W-1:0] exp_rx);
    check({tag, "_ready"}, {31'd0, tx_ready}, 32'd1);
    check({tag, "_busy"},  {31'd0, busy},     32'd0);
    check({tag, "_rxv"},   {31'd0, rx_valid}, 32'd0);
    check({tag, "_sdo"},   {31'd0, sdo},      32'd0);
    check({tag, "_rx"},    {24'd0, rx_data},  {24'd0, exp_rx});
  endtask

  // One transfer. sdi_v[i] is the i-th bit presented on sdi in time.
  // abort_at / rst_at: strobe index at which abort / rst is raised (-1 = never).
  task automatic run_xfer(input logic [7:0] tx, input logic [3:0] ln, input bit lsb,
                          input logic [7:0] sdi_v, input int abort_at, input int rst_at);
    int L;
    int n;
    logic [7:0] exp_rx;
    bit exp_bit;
    L = ((ln == 0) || (ln > 8)) ? 8 : int'(ln);
    exp_rx = '0;
    for (int i = 0; i < L; i++) begin
      if (lsb) exp_rx[i] = sdi_v[i];
      else     exp_rx[L-1-i] = sdi_v[i];
    end

    n = 0;
    while (!tx_ready && n < 50) begin
      step();
      n++;
    end
    check("ready_wait", {31'd0, tx_ready}, 32'd1);

    tx_valid = 1'b1; tx_data = tx; len = ln; lsb_first = lsb;
    step();
    tx_valid = 1'b0; tx_data = 8'($urandom); len = 4'($urandom); lsb_first = 1'($urandom);
    check("accept_busy",  {31'd0, busy},     32'd1);
    check("accept_ready", {31'd0, tx_ready}, 32'd0);

    for (int i = 0; i < L; i++) begin
      exp_bit = lsb ? tx[i] : tx[L-1-i];
      repeat ($urandom_range(0, 2)) begin
        tx_valid = 1'($urandom); tx_data = 8'hFF;
        check("sdo_hold", {31'd0, sdo}, {31'd0, exp_bit});
        step();
        tx_valid = 1'b0;
      end
      check("sdo", {31'd0, sdo}, {31'd0, exp_bit});
      shift_en = 1'b1; sdi = sdi_v[i];
      if (i == abort_at) abort = 1'b1;
      if (i == rst_at)   rst   = 1'b1;
      step();
      shift_en = 1'b0; abort = 1'b0; rst = 1'b0; sdi = 1'($urandom);
      if (i == rst_at) begin
        prev_rx = '0;
        check_idle("reset", prev_rx);
        return;
      end
      if (i == abort_at) begin
        check_idle("abort", prev_rx);
        return;
      end
    end

    check("rx_valid", {31'd0, rx_valid}, 32'd1);
    check("rx_data",  {24'd0, rx_data},  {24'd0, exp_rx});
    check("done_busy", {31'd0, busy},    32'd1);
    check("done_sdo",  {31'd0, sdo},     32'd0);
    // abort, shift_en and tx_valid in DONE are all ignored.
    abort = 1'($urandom); shift_en = 1'($urandom); tx_valid = 1'($urandom);
    step();
    abort = 1'b0; shift_en = 1'b0; tx_valid = 1'b0;
    prev_rx = exp_rx;
    check_idle("post_done", prev_rx);
  endtask

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; len = '0; lsb_first = 1'b0;
    shift_en = 1'b0; abort = 1'b0; sdi = 1'b0;
    @(negedge clk);
    step();
    check_idle("in_reset", 8'h00);
    // rst overrides a same-cycle request and strobe.
    tx_valid = 1'b1; shift_en = 1'b1; abort = 1'b1; tx_data = 8'hA5;
    step();
    check_idle("rst_override", 8'h00);
    tx_valid = 1'b0; shift_en = 1'b0; abort = 1'b0; rst = 1'b0;
    step();
    check_idle("after_reset", 8'h00);

    run_xfer(8'hA5, 4'd8, 1'b0, 8'h3C, -1, -1);
    run_xfer(8'h0F, 4'd8, 1'b1, 8'h01, -1, -1);
    run_xfer(8'hFB, 4'd4, 1'b0, 8'h03, -1, -1);
    run_xfer(8'($urandom), 4'd0, 1'b0, 8'($urandom), -1, -1);
    run_xfer(8'($urandom), 4'd12, 1'b1, 8'($urandom), -1, -1);
    run_xfer(8'($urandom), 4'd8, 1'b0, 8'($urandom), 3, -1);
    run_xfer(8'h55, 4'd8, 1'b0, 8'h96, -1, -1);
    run_xfer(8'($urandom), 4'd8, 1'b1, 8'($urandom), -1, 5);
    run_xfer(8'h5A, 4'd1, 1'b1, 8'h01, -1, -1);

    for (int t = 0; t < 250; t++) begin
      int ab;
      int rs;
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      rs = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1;
      // Idle strobes must not disturb anything.
      repeat ($urandom_range(0, 2)) begin
        shift_en = 1'b1; sdi = 1'($urandom); abort = 1'($urandom);
        check("idle_sdo", {31'd0, sdo}, 32'd0);
        step();
        shift_en = 1'b0; abort = 1'b0;
        check_idle("idle_strobe", prev_rx);
      end
      run_xfer(8'($urandom), 4'($urandom), 1'($urandom), 8'($urandom), ab, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
